sd_dat_rx: RTL and testbench

//  Receives one SD data block on DAT0 (1-bit bus mode), card-to-host direction. Detects the start bit, de-serialises

---
 rtl/sd_dat_rx_pkg.sv | 16 +
 rtl/sd_crc16_sync.sv | 29 ++
 rtl/sd_dat_rx.sv | 178 +++++++++++++++++
 tb/tb_sd_dat_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_rx_pkg.sv
// Shared definitions for the SD DAT0 receive path: FSM states and CRC16 constants.
package sd_dat_rx_pkg;

    localparam int unsigned CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_END        = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/sd_crc16_sync.sv
// Serial CRC16 LFSR (x^16+x^12+x^5+1), MSB-first, zero init.
// Feeding the message followed by its CRC leaves a zero remainder.
// Ports: iclk/irst clock and sync reset, iclr sync clear, ien shift enable,
//        ibit serial input, ocrc current 16-bit remainder.
module sd_crc16_sync
    import sd_dat_rx_pkg::*;
(
    input  logic             iclk,
    input  logic             irst,
    input  logic             iclr,
    input  logic             ien,
    input  logic             ibit,
    output logic [CRC_W-1:0] ocrc
);

    logic fb;

    assign fb = ibit ^ ocrc[CRC_W-1];

    // One LFSR step per enabled cycle
    always_ff @(posedge iclk) begin
        if (irst || iclr) begin
            ocrc <= '0;
        end else if (ien) begin
            ocrc <= {ocrc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/sd_dat_rx.sv
// SD data block receiver, DAT0 only (1-bit bus mode), card-to-host.
// Finds the start bit, deserialises BLOCK_BYTES bytes MSB first, checks
// the trailing CRC16 and the end bit, then pulses odone with status.
// Ports: iclk/irst clock and sync reset; istart arm pulse; istrobe SD-clock
//        sample enable; idat DAT0; obyte/obyte_valid byte stream; obusy,
//        odone, ocrc_err, oend_err, otimeout block status.
module sd_dat_rx
    import sd_dat_rx_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       istart,
    input  logic       istrobe,
    input  logic       idat,
    output logic [7:0] obyte,
    output logic       obyte_valid,
    output logic       obusy,
    output logic       odone,
    output logic       ocrc_err,
    output logic       oend_err,
    output logic       otimeout
);

    localparam int unsigned BIT_W = $clog2(8 * BLOCK_BYTES) + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(8 * BLOCK_BYTES - 1);
    localparam logic [BIT_W-1:0] CRC_LAST  = BIT_W'(CRC_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       byte_sr;
    logic [CRC_W-1:0] crc;

    logic start_acc;
    logic to_inc;
    logic to_hit;
    logic crc_en;
    logic shift_en;
    logic byte_last;
    logic bit_inc;
    logic bit_clr;
    logic end_smp;

    sd_crc16_sync u_crc (
        .iclk (iclk),
        .irst (irst),
        .iclr (start_acc),
        .ien  (crc_en),
        .ibit (idat),
        .ocrc (crc)
    );

    // State register
    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the FSM only advances on strobed samples
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (istart) state_nxt = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (istrobe) begin
                    if (!idat)                   state_nxt = ST_DATA;
                    else if (to_cnt == TO_LAST)  state_nxt = ST_DONE;
                end
            end
            ST_DATA: begin
                if (istrobe && bit_cnt == DATA_LAST) state_nxt = ST_CRC;
            end
            ST_CRC: begin
                if (istrobe && bit_cnt == CRC_LAST) state_nxt = ST_END;
            end
            ST_END: begin
                if (istrobe) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath control strobes decoded from state and sample enable
    always_comb begin
        start_acc = 1'b0;
        to_inc    = 1'b0;
        to_hit    = 1'b0;
        crc_en    = 1'b0;
        shift_en  = 1'b0;
        byte_last = 1'b0;
        bit_inc   = 1'b0;
        bit_clr   = 1'b0;
        end_smp   = 1'b0;
        case (state)
            ST_IDLE: begin
                start_acc = istart;
            end
            ST_WAIT_START: begin
                to_inc = istrobe && idat;
                to_hit = istrobe && idat && (to_cnt == TO_LAST);
            end
            ST_DATA: begin
                crc_en    = istrobe;
                shift_en  = istrobe;
                byte_last = istrobe && (bit_cnt[2:0] == 3'd7);
                bit_inc   = istrobe && (bit_cnt != DATA_LAST);
                bit_clr   = istrobe && (bit_cnt == DATA_LAST);
            end
            ST_CRC: begin
                crc_en  = istrobe;
                bit_inc = istrobe && (bit_cnt != CRC_LAST);
                bit_clr = istrobe && (bit_cnt == CRC_LAST);
            end
            ST_END: begin
                end_smp = istrobe;
            end
            default: begin
            end
        endcase
    end

    // Registered outputs, counters and byte assembler
    always_ff @(posedge iclk) begin
        if (irst) begin
            bit_cnt     <= '0;
            to_cnt      <= '0;
            byte_sr     <= '0;
            obyte       <= '0;
            obyte_valid <= 1'b0;
            obusy       <= 1'b0;
            odone       <= 1'b0;
            ocrc_err    <= 1'b0;
            oend_err    <= 1'b0;
            otimeout    <= 1'b0;
        end else begin
            obyte_valid <= byte_last;
            odone       <= (state_nxt == ST_DONE);
            obusy       <= (state_nxt != ST_IDLE);

            if (start_acc) begin
                bit_cnt  <= '0;
                to_cnt   <= '0;
                byte_sr  <= '0;
                ocrc_err <= 1'b0;
                oend_err <= 1'b0;
                otimeout <= 1'b0;
            end
            if (to_inc)  to_cnt  <= to_cnt + TO_W'(1);
            if (to_hit)  otimeout <= 1'b1;
            if (bit_inc) bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_clr) bit_cnt <= '0;
            if (shift_en) byte_sr <= {byte_sr[6:0], idat};
            if (byte_last) obyte <= {byte_sr[6:0], idat};
            // LFSR already holds the remainder after all 16 CRC bits
            if (end_smp) begin
                ocrc_err <= (crc != '0);
                oend_err <= ~idat;
            end
        end
    end

endmodule

// File: tb/tb_sd_dat_rx.sv
// Self-checking bench for sd_dat_rx: directed block scenarios plus random
// data and random strobe gaps, against a byte-wise CRC16 reference model.
module tb_sd_dat_rx;

    localparam int BB = 512;
    localparam int TO = 1024;

    logic       iclk = 1'b0;
    logic       irst;
    logic       istart;
    logic       istrobe;
    logic       idat;
    logic [7:0] obyte;
    logic       obyte_valid;
    logic       obusy;
    logic       odone;
    logic       ocrc_err;
    logic       oend_err;
    logic       otimeout;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;
    int max_gap   = 0;
    bit poke_start = 1'b0;

    logic [7:0] blk [BB];

    sd_dat_rx #(.BLOCK_BYTES(BB), .TIMEOUT(TO)) dut (
        .iclk        (iclk),
        .irst        (irst),
        .istart      (istart),
        .istrobe     (istrobe),
        .idat        (idat),
        .obyte       (obyte),
        .obyte_valid (obyte_valid),
        .obusy       (obusy),
        .odone       (odone),
        .ocrc_err    (ocrc_err),
        .oend_err    (oend_err),
        .otimeout    (otimeout)
    );

    always #5 iclk = ~iclk;

    // Pulse counters sampled mid-cycle
    always @(negedge iclk) begin
        if (obyte_valid) valid_cnt++;
        if (odone)       done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Reference CRC16-CCITT (init 0) over the block, computed byte-wise
    function automatic logic [15:0] crc_ref();
        logic [15:0] c = 16'h0000;
        for (int i = 0; i < BB; i++) begin
            c = c ^ {blk[i], 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? (16'(c << 1) ^ 16'h1021) : 16'(c << 1);
        end
        return c;
    endfunction

    // One sampled bit, optionally preceded by random idle cycles
    task automatic strobe_bit(input logic b);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
        repeat (g) begin
            if (poke_start && ($urandom_range(0, 15) == 0)) istart = 1'b1;
            idat = 1'($urandom);
            tick();
            istart = 1'b0;
        end
        istrobe = 1'b1;
        idat    = b;
        tick();
        istrobe = 1'b0;
        idat    = 1'($urandom);
    endtask

    // Arm with a coincident 0-valued strobe that must not be taken as a start bit
    task automatic arm(input string tag);
        istart  = 1'b1;
        istrobe = 1'b1;
        idat    = 1'b0;
        tick();
        istart  = 1'b0;
        istrobe = 1'b0;
        idat    = 1'b1;
        check({tag, "_busy"}, 32'(obusy), 32'd1);
        check({tag, "_flags_clr"}, 32'({ocrc_err, oend_err, otimeout}), 32'd0);
    endtask

    task automatic run_block(input string tag, input logic [15:0] crc, input logic endb,
                             input logic exp_crc, input logic exp_end);
        int v0;
        int d0;
        int bad;
        v0  = valid_cnt;
        d0  = done_cnt;
        bad = 0;
        arm(tag);
        repeat ($urandom_range(0, 3)) strobe_bit(1'b1);
        strobe_bit(1'b0);
        for (int i = 0; i < BB; i++) begin
            for (int b = 7; b >= 0; b--) strobe_bit(blk[i][b]);
            if ({obyte_valid, obyte} !== {1'b1, blk[i]}) begin
                if (bad == 0) check({tag, "_byte"}, 32'({obyte_valid, obyte}), 32'({1'b1, blk[i]}));
                bad++;
            end
        end
        check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
        for (int b = 15; b >= 0; b--) strobe_bit(crc[b]);
        check({tag, "_no_early_done"}, 32'(done_cnt - d0), 32'd0);
        strobe_bit(endb);
        check({tag, "_done"}, 32'(odone), 32'd1);
        check({tag, "_crc_err"}, 32'(ocrc_err), 32'(exp_crc));
        check({tag, "_end_err"}, 32'(oend_err), 32'(exp_end));
        check({tag, "_timeout"}, 32'(otimeout), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'({odone, obusy}), 32'd0);
        check({tag, "_flags_held"}, 32'({ocrc_err, oend_err}), 32'({exp_crc, exp_end}));
        check({tag, "_valid_cnt"}, 32'(valid_cnt - v0), 32'(BB));
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int v0;
        int d0;
        logic [15:0] c;
        irst    = 1'b1;
        istart  = 1'b0;
        istrobe = 1'b0;
        idat    = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'({obyte, obyte_valid, obusy, odone, ocrc_err, oend_err, otimeout}), 32'd0);
        irst = 1'b0;
        tick();
        check("idle_outputs", 32'({obyte_valid, obusy, odone}), 32'd0);

        // 1: all-ones block with known CRC
        foreach (blk[i]) blk[i] = 8'hFF;
        run_block("t1", 16'h7FA1, 1'b1, 1'b0, 1'b0);

        // 2: all-zero block, then a single flipped CRC bit
        foreach (blk[i]) blk[i] = 8'h00;
        run_block("t2", 16'h0000, 1'b1, 1'b0, 1'b0);
        run_block("t2_flip", 16'h0400, 1'b1, 1'b1, 1'b0);

        // 3: random valid block with bad end bit
        foreach (blk[i]) blk[i] = 8'($urandom);
        c = crc_ref();
        run_block("t3", c, 1'b0, 1'b0, 1'b1);

        // Random block, good CRC and end bit
        foreach (blk[i]) blk[i] = 8'($urandom);
        c = crc_ref();
        run_block("trand", c, 1'b1, 1'b0, 1'b0);

        // Random block with one random CRC bit corrupted
        c = crc_ref() ^ 16'(16'h1 << $urandom_range(0, 15));
        run_block("trand_bad", c, 1'b1, 1'b1, 1'b0);

        // 4: start bit never arrives
        v0 = valid_cnt;
        d0 = done_cnt;
        arm("t4");
        repeat (TO - 1) strobe_bit(1'b1);
        check("t4_no_done_yet", 32'({odone, 32'(done_cnt - d0) != 0}), 32'd0);
        strobe_bit(1'b1);
        check("t4_done", 32'(odone), 32'd1);
        check("t4_timeout", 32'(otimeout), 32'd1);
        check("t4_other_flags", 32'({ocrc_err, oend_err}), 32'd0);
        tick();
        check("t4_held", 32'({otimeout, obusy, odone}), 32'b100);
        check("t4_no_bytes", 32'(valid_cnt - v0), 32'd0);

        // 5: sparse random strobes and stray istart during the block
        foreach (blk[i]) blk[i] = 8'hFF;
        max_gap    = 5;
        poke_start = 1'b1;
        run_block("t5", 16'h7FA1, 1'b1, 1'b0, 1'b0);
        max_gap    = 0;
        poke_start = 1'b0;

        // 6: reset in the middle of DATA
        d0 = done_cnt;
        arm("t6");
        strobe_bit(1'b0);
        for (int i = 0; i < 10; i++)
            for (int b = 7; b >= 0; b--) strobe_bit(blk[i][b]);
        irst = 1'b1;
        tick();
        irst = 1'b0;
        check("t6_reset_outputs", 32'({obyte, obyte_valid, obusy, odone, ocrc_err, oend_err, otimeout}), 32'd0);
        repeat (20) strobe_bit(1'b0);
        check("t6_stays_idle", 32'({obusy, obyte_valid}), 32'd0);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        run_block("t6_after", 16'h7FA1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
